// File: rtl/mat_loader.sv
// Operand loader for the matrix multiply/add unit: assembles A then B from a
// serial valid/ready stream, checks framing via s_last, and issues both with a strobe.
module mat_loader #(
   parameter int W_IN = 8,
   parameter int N    = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic signed [W_IN-1:0]             s_data,
   input  logic                               s_mode,
   input  logic                               s_last,
   input  logic                               hold,
   output logic                               out_valid,
   output logic                               out_mode,
   output logic [N-1:0][N-1:0][W_IN-1:0]      matrix_1,
   output logic [N-1:0][N-1:0][W_IN-1:0]      matrix_2,
   output logic                               frame_err
);

   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      ISSUE
   } state_e;

   state_e                          state_q, state_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic                            mode_q, mode_d;
   logic                            err_q, err_d;
   logic [N-1:0][N-1:0][W_IN-1:0]   m1_q, m1_d;
   logic [N-1:0][N-1:0][W_IN-1:0]   m2_q, m2_d;

   logic            accept;
   logic            at_end;
   logic            final_pos;
   logic [RW-1:0]   row;
   logic [RW-1:0]   col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         m1_q    <= '0;
         m2_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
      end
   end

   // s_ready is also gated by rst so nothing is offered while reset is held
   assign s_ready   = (state_q != ISSUE) && !rst;
   assign accept    = s_valid && s_ready;
   assign at_end    = (idx_q == IW'(NE - 1));
   assign final_pos = (state_q == LOAD_B) && at_end;
   assign row       = RW'(idx_q / IW'(N));
   assign col       = RW'(idx_q % IW'(N));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mode_d    = mode_q;
      err_d     = 1'b0;
      m1_d      = m1_q;
      m2_d      = m2_q;
      out_valid = 1'b0;
      case (state_q)
         LOAD_A, LOAD_B: begin
            if (accept) begin
               // a misplaced or missing s_last drops the element and restarts the frame
               if (s_last != final_pos) begin
                  err_d   = 1'b1;
                  state_d = LOAD_A;
                  idx_d   = '0;
               end else begin
                  if (state_q == LOAD_A) begin
                     m1_d[row][col] = s_data;
                     if (idx_q == '0) mode_d = s_mode;
                  end else begin
                     m2_d[row][col] = s_data;
                  end
                  if (at_end) begin
                     idx_d   = '0;
                     state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
         end
         ISSUE: begin
            if (!hold) begin
               out_valid = 1'b1;
               state_d   = LOAD_A;
            end
         end
         default: begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
      endcase
   end

   assign out_mode  = mode_q;
   assign frame_err = err_q;
   assign matrix_1  = m1_q;
   assign matrix_2  = m2_q;

endmodule

// File: tb/tb_mat_loader.sv
// Self-checking bench for mat_loader: directed vector table, multi-cycle corner
// sequences and a randomized run against a frame-position reference model.
module tb_mat_loader;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int NN = N * N;

   logic clk = 1'b0;
   logic rst, s_valid, s_mode, s_last, hold;
   logic signed [W-1:0] s_data;
   logic s_ready, out_valid, out_mode, frame_err;
   logic [N-1:0][N-1:0][W-1:0] matrix_1, matrix_2;

   int nerr = 0;
   int nchk = 0;

   mat_loader #(.W_IN(W), .N(N)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_mode(s_mode), .s_last(s_last), .hold(hold),
      .out_valid(out_valid), .out_mode(out_mode),
      .matrix_1(matrix_1), .matrix_2(matrix_2), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // reference model: position of the next element within the frame
   int unsigned pos;
   bit issuing, mmode, merr;
   logic signed [W-1:0] em1 [N][N];
   logic signed [W-1:0] em2 [N][N];

   typedef struct {
      bit                  v;
      logic signed [W-1:0] d;
      bit                  m;
      bit                  l;
      bit                  h;
      bit                  er;
      bit                  eo;
   } vec_t;
   vec_t tab[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [N-1:0][N-1:0][W-1:0] pack_m(input logic signed [W-1:0] a [N][N]);
      logic [N-1:0][N-1:0][W-1:0] r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) r[i][j] = a[i][j];
      return r;
   endfunction

   function automatic logic [N-1:0][N-1:0][W-1:0] pack_i(input int a [N][N]);
      logic [N-1:0][N-1:0][W-1:0] r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) r[i][j] = W'(a[i][j]);
      return r;
   endfunction

   task automatic model_reset();
      pos = 0; issuing = 0; mmode = 0; merr = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin em1[i][j] = '0; em2[i][j] = '0; end
   endtask

   task automatic check_model();
      chk("s_ready",   64'(s_ready),   64'(!issuing));
      chk("out_valid", 64'(out_valid), 64'(issuing && !hold));
      chk("frame_err", 64'(frame_err), 64'(merr));
      chk("out_mode",  64'(out_mode),  64'(mmode));
      chk("matrix_1",  64'(matrix_1),  64'(pack_m(em1)));
      chk("matrix_2",  64'(matrix_2),  64'(pack_m(em2)));
   endtask

   task automatic model_edge();
      merr = 0;
      if (issuing) begin
         if (!hold) issuing = 0;
      end else if (s_valid) begin
         if (s_last != (pos == 2 * NN - 1)) begin
            merr = 1;
            pos  = 0;
         end else begin
            if (pos < NN) em1[pos / N][pos % N] = s_data;
            else          em2[(pos - NN) / N][(pos - NN) % N] = s_data;
            if (pos == 0) mmode = s_mode;
            pos++;
            if (pos == 2 * NN) begin
               pos = 0;
               issuing = 1;
            end
         end
      end
   endtask

   // entered and left at posedge+1
   task automatic step(input bit v, input logic signed [W-1:0] d, input bit m, input bit l, input bit h);
      s_valid = v; s_data = d; s_mode = m; s_last = l; hold = h;
      #1;
      check_model();
      model_edge();
      @(posedge clk); #1;
   endtask

   task automatic step_vec(input vec_t t);
      s_valid = t.v; s_data = t.d; s_mode = t.m; s_last = t.l; hold = t.h;
      #1;
      chk("tab_ready", 64'(s_ready),   64'(t.er));
      chk("tab_valid", 64'(out_valid), 64'(t.eo));
      check_model();
      model_edge();
      @(posedge clk); #1;
   endtask

   task automatic add(input bit v, input int d, input bit m, input bit l, input bit h, input bit er, input bit eo);
      vec_t t;
      t.v = v; t.d = W'(d); t.m = m; t.l = l; t.h = h; t.er = er; t.eo = eo;
      tab.push_back(t);
   endtask

   // streams a frame base..base+2NN-1; gaps of two idle cycles after the listed element counts
   task automatic frame(input int base, input bit m, input bit gaps);
      for (int k = 0; k < 2 * NN; k++) begin
         if (gaps && (k == 3 || k == 6)) begin
            step(0, '0, 0, 0, 0);
            step(0, '0, 0, 0, 0);
         end
         step(1, W'(base + k), m, k == 2 * NN - 1, 0);
      end
   endtask

   int e_a [N][N];
   int e_b [N][N];

   initial begin
      rst = 1; s_valid = 0; s_data = '0; s_mode = 0; s_last = 0; hold = 0;
      model_reset();
      #2;
      chk("rst_ready",  64'(s_ready),   64'(0));
      chk("rst_valid",  64'(out_valid), 64'(0));
      chk("rst_err",    64'(frame_err), 64'(0));
      chk("rst_mode",   64'(out_mode),  64'(0));
      chk("rst_m1",     64'(matrix_1),  64'(0));
      chk("rst_m2",     64'(matrix_2),  64'(0));
      @(posedge clk); #3 rst = 0;
      @(posedge clk); #1;

      // multiply frame, then add frame with a three-cycle hold
      for (int k = 1; k <= 8; k++) add(1, k, 0, k == 8, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 8; k++) add(1, (k < 4) ? -(k + 1) : 10 * (k - 3), 1, k == 7, 0, 1, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < tab.size(); i++) begin
         step_vec(tab[i]);
         if (i == 8) begin
            e_a = '{'{1, 2}, '{3, 4}}; e_b = '{'{5, 6}, '{7, 8}};
            chk("mul_m1", 64'(matrix_1), 64'(pack_i(e_a)));
            chk("mul_m2", 64'(matrix_2), 64'(pack_i(e_b)));
            chk("mul_mode", 64'(out_mode), 64'(0));
         end
      end
      chk("add_mode", 64'(out_mode), 64'(1));
      chk("add_m2_11", 64'(matrix_2[1][1]), 64'(40));
      e_a = '{'{-1, -2}, '{-3, -4}};
      chk("add_m1", 64'(matrix_1), 64'(pack_i(e_a)));

      // source gaps
      frame(1, 0, 1);
      e_a = '{'{1, 2}, '{3, 4}}; e_b = '{'{5, 6}, '{7, 8}};
      chk("gap_m1", 64'(matrix_1), 64'(pack_i(e_a)));
      chk("gap_m2", 64'(matrix_2), 64'(pack_i(e_b)));
      step(0, '0, 0, 0, 0);

      // early s_last on element 5
      for (int k = 1; k <= 5; k++) step(1, W'(k), 0, k == 5, 0);
      chk("early_err", 64'(frame_err), 64'(1));
      chk("early_ready", 64'(s_ready), 64'(1));
      frame(9, 0, 0);
      e_a = '{'{9, 10}, '{11, 12}};
      chk("early_next_m1", 64'(matrix_1), 64'(pack_i(e_a)));
      step(0, '0, 0, 0, 0);

      // missing s_last
      for (int k = 1; k <= 8; k++) step(1, W'(k + 100), 1, 0, 0);
      chk("miss_err", 64'(frame_err), 64'(1));
      chk("miss_valid", 64'(out_valid), 64'(0));
      step(0, '0, 0, 0, 0);

      // asynchronous reset after element 6
      for (int k = 1; k <= 6; k++) step(1, W'(k + 50), 1, 0, 0);
      s_valid = 0;
      #2 rst = 1;
      #1;
      model_reset();
      chk("arst_valid", 64'(out_valid), 64'(0));
      chk("arst_err",   64'(frame_err), 64'(0));
      chk("arst_ready", 64'(s_ready),   64'(0));
      chk("arst_m1",    64'(matrix_1),  64'(0));
      chk("arst_m2",    64'(matrix_2),  64'(0));
      @(posedge clk); @(posedge clk); #2 rst = 0;
      @(posedge clk); #1;
      frame(21, 1, 0);
      e_a = '{'{21, 22}, '{23, 24}}; e_b = '{'{25, 26}, '{27, 28}};
      chk("post_m1", 64'(matrix_1), 64'(pack_i(e_a)));
      chk("post_m2", 64'(matrix_2), 64'(pack_i(e_b)));
      chk("post_valid", 64'(out_valid), 64'(1));
      step(0, '0, 0, 0, 0);

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         bit v, l, h;
         v = ($urandom_range(0, 3) != 0);
         l = (pos == 2 * NN - 1);
         if ($urandom_range(0, 19) == 0) l = !l;
         h = ($urandom_range(0, 2) == 0);
         step(v, W'($urandom), 1'($urandom), l, h);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
